// File: rtl/retire_reporter.sv
// Retire reporter: counts retirements, exposes last result, detects the two-word halt sequence; 1-cycle latency, no backpressure.
// Optional RETIRE_CYCLE_CNT_EN adds a free-running CYCLE_CNT that freezes once halted.
module retire_reporter #(
  parameter logic [31:0] HALT_INST0 = 32'h00C00093,
  parameter logic [31:0] HALT_INST1 = 32'h00008067
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RET_VALID,
  input  logic [31:0] RET_INST,
  input  logic        RET_RD_WE,
  input  logic [31:0] RET_RD_DATA,
  input  logic [11:0] RET_MEM_ADDR,
  input  logic        RET_BR_TAKEN,
  output logic [31:0] NUM_INST,
  output logic [31:0] OUTPUT_PORT,
`ifdef RETIRE_CYCLE_CNT_EN
  output logic [31:0] CYCLE_CNT,
`endif
  output logic        HALT
);

  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_ARMED  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] num_inst_q, num_inst_d;
  logic [31:0] out_port_q, out_port_d;
  logic        halt_q;
  logic [6:0]  opcode;

  assign opcode = RET_INST[6:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_RUN;
      num_inst_q <= 32'd0;
      out_port_q <= 32'd0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_inst_q <= num_inst_d;
      out_port_q <= out_port_d;
      halt_q     <= (state_d == S_HALTED);
    end
  end

  // Count, result and halt-sequence tracking all derive from the same retirement.
  always_comb begin
    state_d    = state_q;
    num_inst_d = num_inst_q;
    out_port_d = out_port_q;
    if (RET_VALID && (state_q != S_HALTED)) begin
      num_inst_d = num_inst_q + 32'd1;
      if (opcode == OPC_STORE)
        out_port_d = {20'b0, RET_MEM_ADDR};
      else if (opcode == OPC_BRANCH)
        out_port_d = {31'b0, RET_BR_TAKEN};
      else if (RET_RD_WE)
        out_port_d = RET_RD_DATA;

      case (state_q)
        S_RUN: begin
          if (RET_INST == HALT_INST0)
            state_d = S_ARMED;
        end
        S_ARMED: begin
          if (RET_INST == HALT_INST1)
            state_d = S_HALTED;
          else if (RET_INST == HALT_INST0)
            state_d = S_ARMED;
          else
            state_d = S_RUN;
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign NUM_INST    = num_inst_q;
  assign OUTPUT_PORT = out_port_q;
  assign HALT        = halt_q;

`ifdef RETIRE_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      cycle_cnt_q <= 32'd0;
    else if (state_q != S_HALTED)
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
  end

  assign CYCLE_CNT = cycle_cnt_q;
`endif

endmodule
